// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: next-PC selection, imem req/ack handshake, wrong-path squash.
// Latency: redirects reach o_next_pc combinationally; a new request issues the cycle after ack.
// Backpressure: i_stall holds the sequencer in IDLE after an ack; it is ignored while a request is outstanding.
//
// Ports:
//   i_clk, i_reset (async, active-low)
//   i_pc / o_next_pc                      : pc register readback and next value
//   i_stall                               : decode not accepting, blocks issue of a new fetch
//   i_branch_taken/_target, i_jump/_target, i_trap : redirect pulses (trap > jump > branch)
//   o_imem_req, o_imem_addr, i_imem_ack   : instruction memory handshake
//   o_instr_valid, o_instr_pc             : returned instruction is on the correct path
//   o_misaligned                          : accepted branch/jump target had [1:0] != 0
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_pc,
  output logic [31:0] o_next_pc,
  input  logic        i_stall,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  input  logic        i_jump,
  input  logic [31:0] i_jump_target,
  input  logic        i_trap,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  output logic        o_instr_valid,
  output logic [31:0] o_instr_pc,
  output logic        o_misaligned
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    IDLE  = 2'd1,
    FETCH = 2'd2
  } state_t;

  // Redirect priority encoding: larger value wins.
  localparam logic [1:0] PRIO_BRANCH = 2'd1;
  localparam logic [1:0] PRIO_JUMP   = 2'd2;
  localparam logic [1:0] PRIO_TRAP   = 2'd3;

  state_t      state_q;
  logic        pend_vld_q;
  logic [1:0]  pend_prio_q;
  logic [31:0] pend_tgt_q;

  logic        redir_vld;
  logic [1:0]  redir_prio;
  logic [31:0] raw_tgt;
  logic        redir_mis;
  logic [31:0] redir_tgt;
  logic        fetch_st;
  logic        ack_ok;
  logic        accept;

  // Same-cycle redirect arbitration.
  always_comb begin
    redir_vld  = i_trap | i_jump | i_branch_taken;
    redir_prio = 2'd0;
    raw_tgt    = i_branch_target;
    if (i_trap) begin
      redir_prio = PRIO_TRAP;
      raw_tgt    = TRAP_VECTOR;
    end else if (i_jump) begin
      redir_prio = PRIO_JUMP;
      raw_tgt    = i_jump_target;
    end else if (i_branch_taken) begin
      redir_prio = PRIO_BRANCH;
      raw_tgt    = i_branch_target;
    end
    // The trap vector is aligned by construction, so only branch/jump can misalign.
    redir_mis = redir_vld && !i_trap && (raw_tgt[1:0] != 2'b00);
    redir_tgt = redir_mis ? TRAP_VECTOR : raw_tgt;
  end

  assign fetch_st = (state_q == FETCH);
  assign ack_ok   = fetch_st && i_imem_ack;

  // A redirect is accepted when it is applied or latched. At ack an already
  // pending target wins, so a new redirect that cycle is not accepted.
  always_comb begin
    accept = 1'b0;
    if (!fetch_st) begin
      accept = redir_vld;
    end else if (ack_ok) begin
      accept = redir_vld && !pend_vld_q;
    end else begin
      accept = redir_vld && (!pend_vld_q || (redir_prio >= pend_prio_q));
    end
  end

  always_comb begin
    o_next_pc = i_pc;
    if (!i_reset) begin
      o_next_pc = RESET_VECTOR;
    end else begin
      case (state_q)
        BOOT:    o_next_pc = redir_vld ? redir_tgt : RESET_VECTOR;
        IDLE:    o_next_pc = redir_vld ? redir_tgt : i_pc;
        FETCH: begin
          if (ack_ok) begin
            if (pend_vld_q)     o_next_pc = pend_tgt_q;
            else if (redir_vld) o_next_pc = redir_tgt;
            else                o_next_pc = i_pc + 32'd4;
          end else begin
            o_next_pc = i_pc;
          end
        end
        default: o_next_pc = RESET_VECTOR;
      endcase
    end
  end

  // Request is a decode of registered state, so it drops with the async reset.
  assign o_imem_req    = fetch_st;
  assign o_imem_addr   = i_pc;
  assign o_instr_valid = ack_ok && !pend_vld_q && !redir_vld;
  assign o_instr_pc    = o_instr_valid ? i_pc : 32'h0000_0000;
  assign o_misaligned  = i_reset && accept && redir_mis;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= BOOT;
      pend_vld_q  <= 1'b0;
      pend_prio_q <= 2'd0;
      pend_tgt_q  <= 32'h0000_0000;
    end else begin
      case (state_q)
        BOOT: state_q <= IDLE;
        IDLE: if (!i_stall) state_q <= FETCH;
        FETCH: begin
          if (ack_ok) begin
            state_q    <= i_stall ? IDLE : FETCH;
            pend_vld_q <= 1'b0;
          end else if (accept) begin
            // Wrong-path fetch outstanding: remember where to go once it returns.
            pend_vld_q  <= 1'b1;
            pend_prio_q <= redir_prio;
            pend_tgt_q  <= redir_tgt;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR  = 32'h0000_0100;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_pc;
  logic [31:0] o_next_pc;
  logic        i_stall;
  logic        i_branch_taken;
  logic [31:0] i_branch_target;
  logic        i_jump;
  logic [31:0] i_jump_target;
  logic        i_trap;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack;
  logic        o_instr_valid;
  logic [31:0] o_instr_pc;
  logic        o_misaligned;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  logic        force_pc = 1'b0;
  logic [31:0] force_val = 32'h0;

  pc_fetch_ctrl #(.RESET_VECTOR(RESET_VECTOR), .TRAP_VECTOR(TRAP_VECTOR)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_pc(i_pc), .o_next_pc(o_next_pc),
    .i_stall(i_stall), .i_branch_taken(i_branch_taken), .i_branch_target(i_branch_target),
    .i_jump(i_jump), .i_jump_target(i_jump_target), .i_trap(i_trap),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_ack(i_imem_ack),
    .o_instr_valid(o_instr_valid), .o_instr_pc(o_instr_pc), .o_misaligned(o_misaligned)
  );

  always #5 i_clk = ~i_clk;

  // pc register that the sequencer drives; force_pc lets the bench jump it.
  always @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)      i_pc <= 32'h0;
    else if (force_pc) i_pc <= force_val;
    else               i_pc <= o_next_pc;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every correct-path instruction must match the oldest expected PC.
  always @(negedge i_clk) begin
    logic [31:0] e;
    #3;
    if (i_reset && o_instr_valid) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      chk("instr_pc", o_instr_pc, e);
    end
  end

  task automatic next_cyc();
    @(negedge i_clk);
    i_branch_taken = 1'b0;
    i_jump         = 1'b0;
    i_trap         = 1'b0;
    i_imem_ack     = 1'b0;
    #1;
  endtask

  task automatic wait_req(input logic [31:0] addr);
    int n = 0;
    while (!o_imem_req && n < 20) begin
      next_cyc();
      n++;
    end
    chk("req_seen", {31'b0, o_imem_req}, 32'd1);
    chk("req_addr", o_imem_addr, addr);
  endtask

  task automatic ack_after(input int dly, input logic exp_vld, input logic [31:0] exp_nxt);
    repeat (dly) next_cyc();
    i_imem_ack = 1'b1;
    #1;
    chk("ack_valid", {31'b0, o_instr_valid}, {31'b0, exp_vld});
    chk("ack_next_pc", o_next_pc, exp_nxt);
    next_cyc();
  endtask

  task automatic fetch(input logic [31:0] addr, input int dly);
    logic [31:0] nxt;
    nxt = addr + 32'd4;
    wait_req(addr);
    exp_q.push_back(addr);
    ack_after(dly, 1'b1, nxt);
  endtask

  initial begin
    i_reset = 1'b0; i_stall = 1'b0; i_imem_ack = 1'b0;
    i_branch_taken = 1'b0; i_branch_target = 32'h0;
    i_jump = 1'b0; i_jump_target = 32'h0; i_trap = 1'b0;

    repeat (3) @(negedge i_clk);
    #1;
    chk("rst_req", {31'b0, o_imem_req}, 32'd0);
    chk("rst_next_pc", o_next_pc, RESET_VECTOR);
    chk("rst_valid", {31'b0, o_instr_valid}, 32'd0);
    chk("rst_mis", {31'b0, o_misaligned}, 32'd0);
    chk("rst_instr_pc", o_instr_pc, 32'h0);

    @(negedge i_clk);
    i_reset = 1'b1;
    #1;
    chk("boot_next_pc", o_next_pc, RESET_VECTOR);
    chk("boot_req", {31'b0, o_imem_req}, 32'd0);

    // Sequential fetch after reset.
    fetch(32'h0, 1);
    fetch(32'h4, 1);

    // Jump while 0x8 outstanding: 0x8 squashed, resume at 0x40.
    wait_req(32'h8);
    i_jump = 1'b1; i_jump_target = 32'h40;
    #1;
    chk("jmp_mis", {31'b0, o_misaligned}, 32'd0);
    ack_after(2, 1'b0, 32'h40);
    fetch(32'h40, 1);
    fetch(32'h44, 1);

    // Branch and trap together: trap wins.
    wait_req(32'h48);
    i_branch_taken = 1'b1; i_branch_target = 32'h80; i_trap = 1'b1;
    #1;
    chk("trap_mis", {31'b0, o_misaligned}, 32'd0);
    ack_after(1, 1'b0, TRAP_VECTOR);
    fetch(TRAP_VECTOR, 1);

    // Stall: ignored while req high, then holds IDLE after ack.
    wait_req(32'h104);
    exp_q.push_back(32'h104);
    i_stall = 1'b1;
    next_cyc();
    chk("stall_req_held", {31'b0, o_imem_req}, 32'd1);
    chk("stall_addr_held", o_imem_addr, 32'h104);
    i_imem_ack = 1'b1;
    #1;
    chk("stall_ack_valid", {31'b0, o_instr_valid}, 32'd1);
    chk("stall_ack_next", o_next_pc, 32'h108);
    next_cyc();
    chk("stall_req_drop", {31'b0, o_imem_req}, 32'd0);
    chk("stall_pc", i_pc, 32'h108);
    next_cyc();
    chk("stall_req_idle", {31'b0, o_imem_req}, 32'd0);
    chk("stall_pc_hold", o_next_pc, 32'h108);
    i_stall = 1'b0;
    fetch(32'h108, 1);

    // Misaligned jump target goes to the trap vector.
    wait_req(32'h10C);
    i_jump = 1'b1; i_jump_target = 32'h42;
    #1;
    chk("mis_pulse", {31'b0, o_misaligned}, 32'd1);
    next_cyc();
    chk("mis_one_cycle", {31'b0, o_misaligned}, 32'd0);
    ack_after(0, 1'b0, TRAP_VECTOR);

    // Pending overwrite: branch, then jump (wins), then branch (dropped).
    wait_req(TRAP_VECTOR);
    i_branch_taken = 1'b1; i_branch_target = 32'h200;
    next_cyc();
    i_jump = 1'b1; i_jump_target = 32'h300;
    next_cyc();
    i_branch_taken = 1'b1; i_branch_target = 32'h400;
    ack_after(1, 1'b0, 32'h300);
    fetch(32'h300, 1);

    // Wrap at the top of the address space.
    wait_req(32'h304);
    force_val = 32'hFFFF_FFFC;
    force_pc  = 1'b1;
    @(posedge i_clk);
    #1;
    force_pc = 1'b0;
    @(negedge i_clk);
    #1;
    fetch(32'hFFFF_FFFC, 1);

    // Async reset mid-FETCH with an ack in flight.
    wait_req(32'h0);
    i_imem_ack = 1'b1;
    i_reset    = 1'b0;
    #1;
    chk("arst_req", {31'b0, o_imem_req}, 32'd0);
    chk("arst_valid", {31'b0, o_instr_valid}, 32'd0);
    chk("arst_next_pc", o_next_pc, RESET_VECTOR);
    chk("arst_instr_pc", o_instr_pc, 32'h0);
    next_cyc();
    i_reset = 1'b1;
    #1;
    chk("rerel_req", {31'b0, o_imem_req}, 32'd0);
    fetch(32'h0, 1);

    next_cyc();
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
